// File: rtl/sram_pkg.sv
// Shared constants and types for the asynchronous-SRAM device emulator and its controller.
package sram_pkg;

  localparam int SRAM_ADDR_W       = 17;
  localparam int SRAM_DATA_W       = 16;
  localparam int SRAM_DEF_DEPTH    = 64;
  localparam int SRAM_DEF_READ_LAT = 1;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // Bit 1 is the upper byte lane [15:8], bit 0 the lower lane [7:0].
  typedef logic [1:0] lane_en_t;

  typedef struct packed {
    lane_en_t                lanes;
    logic [SRAM_DATA_W-1:0]  data;
  } rd_beat_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == CNT_MAX) ? cnt : cnt + 16'd1;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-latency shift register: carries a valid bit, the captured word and its lane enables.
module sram_rd_pipe
  import sram_pkg::*;
#(
  parameter int STAGES = SRAM_DEF_READ_LAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  input  logic [1:0]  in_lanes,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic [1:0]  out_lanes
);

  logic [STAGES-1:0] valid_q, valid_d;
  rd_beat_t          beat_q [STAGES];
  rd_beat_t          beat_d [STAGES];

  // NOTE: every always_comb output gets a full assignment up front, so no latch is inferred.
  always_comb begin
    valid_d[0] = in_valid;
    beat_d[0]  = '{lanes: in_lanes, data: in_data};
    for (int i = 1; i < STAGES; i++) begin
      valid_d[i] = valid_q[i-1];
      beat_d[i]  = beat_q[i-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all stages shift on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // NOTE: the data stages carry no reset; the valid bits alone decide whether a beat is used.
  always_ff @(posedge clk) begin
    beat_q <= beat_d;
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_data  = beat_q[STAGES-1].data;
  assign out_lanes = beat_q[STAGES-1].lanes;

endmodule

// File: rtl/sram_device_emulator.sv
// Cycle-based emulator of an asynchronous 16-bit SRAM: byte-lane writes, pipelined reads,
// per-lane tristate data bus, sticky protocol-error flag and saturating access counters.
module sram_device_emulator
  import sram_pkg::*;
#(
  parameter int ADDR_W   = SRAM_ADDR_W,
  parameter int DATA_W   = SRAM_DATA_W,
  parameter int DEPTH    = SRAM_DEF_DEPTH,
  parameter int READ_LAT = SRAM_DEF_READ_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  input  logic              SRAM_WE_N,
  input  logic              SRAM_OE_N,
  input  logic              SRAM_CE_N,
  input  logic              SRAM_UB_N,
  input  logic              SRAM_LB_N,
  output logic              proto_err,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       wr_cnt
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [15:0]      mem_q [DEPTH];
  logic [IDX_W-1:0] word_idx;
  lane_en_t         lanes_on;
  logic             wr_acc, rd_iss, bus_rd;

  logic             proto_err_q, proto_err_d;
  logic [15:0]      rd_cnt_q, rd_cnt_d;
  logic [15:0]      wr_cnt_q, wr_cnt_d;

  logic             pipe_valid;
  logic [15:0]      pipe_data;
  logic [1:0]       pipe_lanes;
  logic             drv_ub, drv_lb;

  assign word_idx = IDX_W'(32'(SRAM_ADDR) % DEPTH);
  assign lanes_on = {~SRAM_UB_N, ~SRAM_LB_N};

  // A low WE_N always wins: that cycle is a write, never a read.
  assign wr_acc = ~SRAM_CE_N & ~SRAM_WE_N;
  assign bus_rd = ~SRAM_CE_N &  SRAM_WE_N & ~SRAM_OE_N;
  assign rd_iss = bus_rd;

  always_comb begin
    proto_err_d = proto_err_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    if (wr_acc) begin
      wr_cnt_d = sat_inc(wr_cnt_q);
      if (!SRAM_OE_N || (SRAM_UB_N && SRAM_LB_N)) proto_err_d = 1'b1;
    end
    if (rd_iss) rd_cnt_d = sat_inc(rd_cnt_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proto_err_q <= 1'b0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
    end else begin
      proto_err_q <= proto_err_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
    end
  end

  // NOTE: storage is reset here on purpose, because the emulated device must read back zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_acc) begin
      if (lanes_on[1]) mem_q[word_idx][15:8] <= SRAM_DQ[15:8];
      if (lanes_on[0]) mem_q[word_idx][7:0]  <= SRAM_DQ[7:0];
    end
  end

  sram_rd_pipe #(
    .STAGES (READ_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_iss),
    .in_data   (mem_q[word_idx]),
    .in_lanes  (lanes_on),
    .out_valid (pipe_valid),
    .out_data  (pipe_data),
    .out_lanes (pipe_lanes)
  );

  // Beats that emerge while the bus is not in a read phase are dropped undriven.
  assign drv_ub = pipe_valid & pipe_lanes[1] & bus_rd;
  assign drv_lb = pipe_valid & pipe_lanes[0] & bus_rd;

  assign SRAM_DQ[15:8] = drv_ub ? pipe_data[15:8] : 8'hzz;
  assign SRAM_DQ[7:0]  = drv_lb ? pipe_data[7:0]  : 8'hzz;

  assign proto_err = proto_err_q;
  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;

endmodule

// File: tb/tb_sram_device_emulator.sv
// Directed bench: three emulator instances (READ_LAT 1, 3, 2) on separate pulled-up buses.
module tb_sram_device_emulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [16:0] addr;
  logic        we_n, oe_n, ub_n, lb_n;
  logic        ce1_n, ce3_n, ce2_n;
  logic [15:0] drv;
  logic        drv_en;

  // A released bus floats high, so high-Z reads back as all ones.
  tri1 [15:0] dq1, dq3, dq2;
  assign dq1 = drv_en ? drv : 16'hzzzz;
  assign dq3 = drv_en ? drv : 16'hzzzz;
  assign dq2 = drv_en ? drv : 16'hzzzz;

  logic        perr1, perr3, perr2;
  logic [15:0] rdc1, rdc3, rdc2, wrc1, wrc3, wrc2;

  localparam logic [15:0] HIZ = 16'hFFFF;

  sram_device_emulator #(.READ_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .SRAM_ADDR(addr), .SRAM_DQ(dq1), .SRAM_WE_N(we_n),
    .SRAM_OE_N(oe_n), .SRAM_CE_N(ce1_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
    .proto_err(perr1), .rd_cnt(rdc1), .wr_cnt(wrc1)
  );

  sram_device_emulator #(.READ_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .SRAM_ADDR(addr), .SRAM_DQ(dq3), .SRAM_WE_N(we_n),
    .SRAM_OE_N(oe_n), .SRAM_CE_N(ce3_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
    .proto_err(perr3), .rd_cnt(rdc3), .wr_cnt(wrc3)
  );

  sram_device_emulator #(.READ_LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .SRAM_ADDR(addr), .SRAM_DQ(dq2), .SRAM_WE_N(we_n),
    .SRAM_OE_N(oe_n), .SRAM_CE_N(ce2_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
    .proto_err(perr2), .rd_cnt(rdc2), .wr_cnt(wrc2)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // sel picks the chip (1, 3 or 2; 0 deselects all); the bench drives DQ only for a clean write.
  task automatic bus(input int sel, input logic we, input logic oe, input logic ub,
                     input logic lb, input logic [16:0] a, input logic [15:0] d);
    ce1_n  = (sel != 1);
    ce3_n  = (sel != 3);
    ce2_n  = (sel != 2);
    we_n   = we;
    oe_n   = oe;
    ub_n   = ub;
    lb_n   = lb;
    addr   = a;
    drv    = d;
    drv_en = ~we & oe;
    #1;
  endtask

  task automatic idle();
    bus(0, 1'b1, 1'b1, 1'b1, 1'b1, 17'd0, 16'h0000);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int sel, input logic [16:0] a, input logic [15:0] d,
                       input logic ub, input logic lb);
    bus(sel, 1'b0, 1'b1, ub, lb, a, d);
    tick();
  endtask

  task automatic read_state(input int sel, input logic [16:0] a);
    bus(sel, 1'b1, 1'b0, 1'b0, 1'b0, a, 16'h0000);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    tick();
    check("rst_perr", 16'(perr1), 16'd0);
    check("rst_rdc",  rdc1, 16'd0);
    check("rst_wrc",  wrc1, 16'd0);

    // Full-word write then read, latency 1
    write(1, 17'd5, 16'hA5C3, 1'b0, 1'b0);
    read_state(1, 17'd5);
    check("t1_pre_issue", dq1, HIZ);
    tick();
    check("t1_rd_data", dq1, 16'hA5C3);
    check("t1_wrc", wrc1, 16'd1);
    check("t1_rdc", rdc1, 16'd1);
    idle();
    check("t1_ce_high", dq1, HIZ);
    tick();

    // Byte-lane write, then a read issued with only the lower lane enabled
    write(1, 17'd3, 16'hFFFF, 1'b0, 1'b0);
    write(1, 17'd3, 16'h1200, 1'b0, 1'b1);
    read_state(1, 17'd3);
    tick();
    check("t2_lane_wr", dq1, 16'h12FF);
    bus(1, 1'b1, 1'b0, 1'b1, 1'b0, 17'd5, 16'h0000);
    tick();
    check("t2_lane_rd", dq1, 16'hFFC3);

    // Violation while a beat is valid: WE_N low keeps the bus released
    bus(1, 1'b0, 1'b0, 1'b0, 1'b0, 17'd0, 16'h0000);
    check("t4_viol_dq", dq1, HIZ);
    tick();
    check("t4_perr", 16'(perr1), 16'd1);
    write(1, 17'd70, 16'h0077, 1'b0, 1'b0);
    read_state(1, 17'd6);
    tick();
    check("t4_wrap", dq1, 16'h0077);
    idle();
    tick();
    check("t4_sticky", 16'(perr1), 16'd1);
    check("t4_wrc", wrc1, 16'd5);
    check("t4_rdc", rdc1, 16'd4);

    // Latency 3 streaming
    write(3, 17'd0, 16'h0001, 1'b0, 1'b0);
    write(3, 17'd1, 16'h0002, 1'b0, 1'b0);
    write(3, 17'd2, 16'h0003, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      read_state(3, 17'(i));
      check($sformatf("t3_pre%0d", i), dq3, HIZ);
      tick();
    end
    read_state(3, 17'd0);
    for (int i = 1; i <= 3; i++) begin
      check($sformatf("t3_stream%0d", i), dq3, 16'(i));
      tick();
    end
    bus(3, 1'b1, 1'b1, 1'b0, 1'b0, 17'd0, 16'h0000);
    check("t3_post_oe_off", dq3, HIZ);
    idle();
    repeat (3) tick();

    // Write to a word whose read is in flight
    read_state(3, 17'd2);
    tick();
    write(3, 17'd2, 16'h0009, 1'b0, 1'b0);
    read_state(3, 17'd2);
    check("t3_if_pre", dq3, HIZ);
    tick();
    check("t3_inflight", dq3, 16'h0003);
    tick();
    check("t3_gap", dq3, HIZ);
    tick();
    check("t3_new_val", dq3, 16'h0009);
    check("t3_rdc", rdc3, 16'd10);
    check("t3_wrc", wrc3, 16'd4);
    idle();
    tick();

    // Latency 2: no-lane write flags an error; then reset mid-read
    write(2, 17'd9, 16'h1234, 1'b1, 1'b1);
    check("t5_perr_nolane", 16'(perr2), 16'd1);
    write(2, 17'd4, 16'hBEEF, 1'b0, 1'b0);
    read_state(2, 17'd4);
    tick();
    check("t5_pre", dq2, HIZ);
    tick();
    check("t5_rd_data", dq2, 16'hBEEF);
    rst = 1'b1;
    #1;
    check("t5_rst_dq",   dq2, HIZ);
    check("t5_rst_perr", 16'(perr2), 16'd0);
    check("t5_rst_rdc",  rdc2, 16'd0);
    check("t5_rst_wrc",  wrc2, 16'd0);
    @(negedge clk) rst = 1'b0;
    tick();
    check("t5_after_pre", dq2, HIZ);
    tick();
    check("t5_after_data", dq2, 16'h0000);
    check("t5_after_rdc",  rdc2, 16'd2);
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
